// File: rtl/vga_timing_gen_if.sv
// Pixel-source and DAC signal bundle for vga_timing_gen; master is the timing
// generator, slave is the frame source / DAC side.
interface vga_timing_gen_if #(
    parameter int CNT_W   = 11,
    parameter int COLOR_W = 10
);
    logic [CNT_W-1:0]   x_addr;
    logic [CNT_W-1:0]   y_addr;
    logic [COLOR_W-1:0] pix_r;
    logic [COLOR_W-1:0] pix_g;
    logic [COLOR_W-1:0] pix_b;
    logic               pix_ce;
    logic               vga_clock;
    logic [COLOR_W-1:0] vga_r;
    logic [COLOR_W-1:0] vga_g;
    logic [COLOR_W-1:0] vga_b;
    logic               vga_hs;
    logic               vga_vs;
    logic               vga_blank_n;
    logic               vga_sync_n;
    logic               line_start;
    logic               frame_start;

    modport master (
        output x_addr, y_addr, pix_ce, vga_clock,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
        output line_start, frame_start,
        input  pix_r, pix_g, pix_b
    );

    modport slave (
        input  x_addr, y_addr, pix_ce, vga_clock,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
        input  line_start, frame_start,
        output pix_r, pix_g, pix_b
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator and registered DAC output stage.
// Define VGA_TIMING_SCALE2X_EN to address a half-resolution source (2x2 pixel replication).
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 2,
    parameter int COLOR_W  = 10,
    parameter int CNT_W    = 11
) (
    input  logic             clock,
    input  logic             reset,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int DIV_W        = $clog2(CLK_DIV);
    localparam logic HS_ACT     = (HS_POL != 0);
    localparam logic VS_ACT     = (VS_POL != 0);

    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;

    logic tick;
    logic h_last;
    logic v_last;
    logic active;
    logic hs_win;
    logic vs_win;

    always_comb begin
        tick   = (div == DIV_W'(CLK_DIV - 1));
        h_last = (h == CNT_W'(H_TOTAL - 1));
        v_last = (v == CNT_W'(V_TOTAL - 1));
        active = (h < CNT_W'(H_ACTIVE)) && (v < CNT_W'(V_ACTIVE));
        hs_win = (h >= CNT_W'(H_SYNC_START)) && (h < CNT_W'(H_SYNC_END));
        vs_win = (v >= CNT_W'(V_SYNC_START)) && (v < CNT_W'(V_SYNC_END));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (tick) begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? '0 : v + CNT_W'(1);
            end else begin
                h <= h + CNT_W'(1);
            end
        end
    end

    // Everything below is captured from the pre-increment h/v, so the DAC lags the address by one tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.vga_r       <= '0;
            bus.vga_g       <= '0;
            bus.vga_b       <= '0;
            bus.vga_blank_n <= 1'b0;
            bus.vga_hs      <= ~HS_ACT;
            bus.vga_vs      <= ~VS_ACT;
        end else if (tick) begin
            bus.vga_r       <= active ? bus.pix_r : '0;
            bus.vga_g       <= active ? bus.pix_g : '0;
            bus.vga_b       <= active ? bus.pix_b : '0;
            bus.vga_blank_n <= active;
            bus.vga_hs      <= hs_win ? HS_ACT : ~HS_ACT;
            bus.vga_vs      <= vs_win ? VS_ACT : ~VS_ACT;
        end
    end

    always_comb begin
`ifdef VGA_TIMING_SCALE2X_EN
        bus.x_addr = active ? (h >> 1) : '1;
        bus.y_addr = active ? (v >> 1) : '1;
`else
        bus.x_addr = active ? h : '1;
        bus.y_addr = active ? v : '1;
`endif
        bus.pix_ce      = tick;
        bus.vga_clock   = (div >= DIV_W'(CLK_DIV / 2));
        bus.vga_sync_n  = 1'b0;
        bus.line_start  = tick && (h == '0);
        bus.frame_start = tick && (h == '0) && (v == '0);
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 15x8 geometry: tick-indexed vector
// table plus hand sequences for reset, periods, divide-by-4 and sync polarity.
module tb_vga_timing_gen;
    logic clock = 1'b0;
    logic reset = 1'b1;
    bit   sel   = 1'b0;

    always #5 clock = ~clock;

    vga_timing_gen_if #(.CNT_W(6), .COLOR_W(4)) ifa ();
    vga_timing_gen_if #(.CNT_W(6), .COLOR_W(4)) ifb ();

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .CLK_DIV(2), .COLOR_W(4), .CNT_W(6)
    ) dut_a (.clock(clock), .reset(reset), .bus(ifa.master));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .CLK_DIV(4), .COLOR_W(4), .CNT_W(6)
    ) dut_b (.clock(clock), .reset(reset), .bus(ifb.master));

    // Frame source: colour encodes the requested address
    assign ifa.pix_r = ifa.x_addr[3:0];
    assign ifa.pix_g = ifa.y_addr[3:0];
    assign ifa.pix_b = 4'hA;
    assign ifb.pix_r = ifb.x_addr[3:0];
    assign ifb.pix_g = ifb.y_addr[3:0];
    assign ifb.pix_b = 4'hA;

    logic m_ce, m_ls, m_fs, m_hs, m_vs, m_bn, m_ck;
    always_comb begin
        if (sel) begin
            m_ce = ifb.pix_ce; m_ls = ifb.line_start; m_fs = ifb.frame_start;
            m_hs = ifb.vga_hs; m_vs = ifb.vga_vs; m_bn = ifb.vga_blank_n; m_ck = ifb.vga_clock;
        end else begin
            m_ce = ifa.pix_ce; m_ls = ifa.line_start; m_fs = ifa.frame_start;
            m_hs = ifa.vga_hs; m_vs = ifa.vga_vs; m_bn = ifa.vga_blank_n; m_ck = ifa.vga_clock;
        end
    end

    typedef struct {
        int         t;
        logic [5:0] x, y;
        logic       ls, fs, hs, vs, bn;
        logic [3:0] r, g, b;
    } vec_t;

    vec_t tbl[17];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cur      = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    function automatic logic [5:0] sc(input logic [5:0] a);
`ifdef VGA_TIMING_SCALE2X_EN
        return (a == 6'h3F) ? a : (a >> 1);
`else
        return a;
`endif
    endfunction

    task automatic next_tick();
        int w = 0;
        do begin
            @(negedge clock);
            w++;
        end while (!m_ce && w < 20);
        if (!m_ce) check("pix_ce_timeout", 0, 1);
    endtask

    task automatic release_latency(input int exp_lat, input string name);
        int n = 0;
        reset = 1'b0;
        do begin
            @(negedge clock);
            n++;
        end while (!m_ce && n < 20);
        check({name, "_first_ce_latency"}, n, exp_lat);
        check({name, "_first_line_start"}, int'(m_ls), 1);
        check({name, "_first_frame_start"}, int'(m_fs), 1);
    endtask

    task automatic run_table(input string tag);
        string s;
        for (int unsigned i = 0; i < 17; i++) begin
            while (cur < tbl[i].t) begin
                next_tick();
                cur++;
            end
            s = $sformatf("%s_t%0d", tag, tbl[i].t);
            check({s, "_x"},  int'(ifa.x_addr),      int'(sc(tbl[i].x)));
            check({s, "_y"},  int'(ifa.y_addr),      int'(sc(tbl[i].y)));
            check({s, "_ls"}, int'(ifa.line_start),  int'(tbl[i].ls));
            check({s, "_fs"}, int'(ifa.frame_start), int'(tbl[i].fs));
            check({s, "_hs"}, int'(ifa.vga_hs),      int'(tbl[i].hs));
            check({s, "_vs"}, int'(ifa.vga_vs),      int'(tbl[i].vs));
            check({s, "_bn"}, int'(ifa.vga_blank_n), int'(tbl[i].bn));
            check({s, "_r"},  int'(ifa.vga_r),       int'(sc({2'b00, tbl[i].r})));
            check({s, "_g"},  int'(ifa.vga_g),       int'(sc({2'b00, tbl[i].g})));
            check({s, "_b"},  int'(ifa.vga_b),       int'(tbl[i].b));
        end
    endtask

    task automatic measure_line(input int exp_period, input string name);
        int w = 0;
        int p = 0;
        while (!m_ls && w < 200) begin
            @(negedge clock);
            w++;
        end
        do begin
            @(negedge clock);
            p++;
        end while (!m_ls && p < 200);
        check({name, "_line_period"}, p, exp_period);
    endtask

    task automatic measure_frame(input logic hs_act, input logic vs_act,
                                 output int period, output int hs_n, output int vs_n,
                                 output int bn_n, output int ck_n);
        int w = 0;
        period = 0; hs_n = 0; vs_n = 0; bn_n = 0; ck_n = 0;
        while (!m_fs && w < 2000) begin
            @(negedge clock);
            w++;
        end
        if (!m_fs) begin
            check("frame_start_wait_timeout", 0, 1);
            return;
        end
        do begin
            if (m_hs == hs_act) hs_n++;
            if (m_vs == vs_act) vs_n++;
            if (m_bn) bn_n++;
            if (m_ck) ck_n++;
            @(negedge clock);
            period++;
        end while (!m_fs && period < 2000);
    endtask

    initial begin
        int p, hs_n, vs_n, bn_n, ck_n;

        //          t    x      y      ls    fs    hs    vs    bn    r      g      b
        tbl[0]  = '{0,   6'h00, 6'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'h0};
        tbl[1]  = '{1,   6'h01, 6'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 4'hA};
        tbl[2]  = '{8,   6'h3F, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 4'd0, 4'hA};
        tbl[3]  = '{9,   6'h3F, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'h0};
        tbl[4]  = '{11,  6'h3F, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'h0};
        tbl[5]  = '{13,  6'h3F, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'h0};
        tbl[6]  = '{14,  6'h3F, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'h0};
        tbl[7]  = '{15,  6'h00, 6'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'h0};
        tbl[8]  = '{18,  6'h03, 6'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 4'd1, 4'hA};
        tbl[9]  = '{61,  6'h3F, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'h0};
        tbl[10] = '{76,  6'h3F, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'h0};
        tbl[11] = '{91,  6'h3F, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'h0};
        tbl[12] = '{106, 6'h3F, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'h0};
        tbl[13] = '{120, 6'h00, 6'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'h0};
        tbl[14] = '{121, 6'h01, 6'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 4'hA};
        tbl[15] = '{127, 6'h07, 6'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd6, 4'd0, 4'hA};
        tbl[16] = '{131, 6'h3F, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'h0};

        // Power-on reset, DUT A
        sel   = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_pix_ce",  int'(ifa.pix_ce),      0);
        check("rst_ls",      int'(ifa.line_start),  0);
        check("rst_fs",      int'(ifa.frame_start), 0);
        check("rst_vga_clk", int'(ifa.vga_clock),   0);
        check("rst_x",       int'(ifa.x_addr),      0);
        check("rst_y",       int'(ifa.y_addr),      0);
        check("rst_hs",      int'(ifa.vga_hs),      1);
        check("rst_vs",      int'(ifa.vga_vs),      1);
        check("rst_bn",      int'(ifa.vga_blank_n), 0);
        check("rst_r",       int'(ifa.vga_r),       0);
        release_latency(1, "a");
        cur = 0;
        run_table("run1");

        // Mid-frame reset at h=5, v=2 landing on a pix_ce edge
        while (cur < 155) begin
            next_tick();
            cur++;
        end
        check("pre_rst_x", int'(ifa.x_addr), int'(sc(6'd5)));
        check("pre_rst_y", int'(ifa.y_addr), int'(sc(6'd2)));
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_pix_ce", int'(ifa.pix_ce),      0);
        check("mid_rst_ls",     int'(ifa.line_start),  0);
        check("mid_rst_x",      int'(ifa.x_addr),      0);
        check("mid_rst_y",      int'(ifa.y_addr),      0);
        check("mid_rst_hs",     int'(ifa.vga_hs),      1);
        check("mid_rst_vs",     int'(ifa.vga_vs),      1);
        check("mid_rst_bn",     int'(ifa.vga_blank_n), 0);
        check("mid_rst_r",      int'(ifa.vga_r),       0);
        check("mid_rst_g",      int'(ifa.vga_g),       0);
        check("mid_rst_clk",    int'(ifa.vga_clock),   0);
        release_latency(1, "a_mid");
        cur = 0;
        run_table("run2");

        check("sync_n", int'(ifa.vga_sync_n), 0);
        measure_line(30, "a");
        measure_frame(1'b0, 1'b0, p, hs_n, vs_n, bn_n, ck_n);
        check("a_frame_period",  p,    240);
        check("a_hs_active_clk", hs_n, 48);
        check("a_vs_active_clk", vs_n, 60);
        check("a_blank_n_clk",   bn_n, 64);
        check("a_vga_clock_hi",  ck_n, 120);

        // DUT B: divide by 4, active-high syncs
        sel   = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("b_rst_hs",  int'(ifb.vga_hs),    0);
        check("b_rst_vs",  int'(ifb.vga_vs),    0);
        check("b_rst_ce",  int'(ifb.pix_ce),    0);
        check("b_rst_clk", int'(ifb.vga_clock), 0);
        release_latency(3, "b");
        check("b_clk_div3", int'(ifb.vga_clock), 1);
        @(negedge clock);
        check("b_clk_div0", int'(ifb.vga_clock), 0);
        @(negedge clock);
        check("b_clk_div1", int'(ifb.vga_clock), 0);
        @(negedge clock);
        check("b_clk_div2", int'(ifb.vga_clock), 1);
        check("b_ce_div2",  int'(ifb.pix_ce),    0);
        measure_line(60, "b");
        measure_frame(1'b1, 1'b1, p, hs_n, vs_n, bn_n, ck_n);
        check("b_frame_period",  p,    480);
        check("b_hs_active_clk", hs_n, 96);
        check("b_vs_active_clk", vs_n, 120);
        check("b_blank_n_clk",   bn_n, 128);
        check("b_vga_clock_hi",  ck_n, 240);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
